reli_tx_mac_arb: RTL and testbench



---
 rtl/reli_tx_pkg.sv | 21 ++
 rtl/reli_tx_out_reg.sv | 73 +++++++
 rtl/reli_tx_mac_arb.sv | 197 +++++++++++++++++++
 tb/tb_reli_tx_mac_arb.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reli_tx_pkg.sv
// ---------------------------------------------------------------------------
// reli_tx_pkg
// Shared definitions for the reliability TX path in front of the MAC.
//   grant_t           : which source currently owns the MAC output stream
//   DEF_DATA_WIDTH    : default AXI-Stream tdata width
//   DEF_USER_WIDTH    : default AXI-Stream tuser width
//   DEF_CNT_WIDTH     : default statistics counter width
// ---------------------------------------------------------------------------
package reli_tx_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_NEW  = 2'd1,
    GNT_RETX = 2'd2
  } grant_t;

  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_USER_WIDTH = 71;
  localparam int DEF_CNT_WIDTH  = 32;

endpackage

// File: rtl/reli_tx_out_reg.sv
// ---------------------------------------------------------------------------
// reli_tx_out_reg
// Single-stage AXI-Stream register feeding the MAC. Carries
// {tdata, tkeep, tlast, tuser, tretx}. It accepts a new beat whenever the
// output slot is empty or being drained in the same cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_t*               : beat from the arbiter mux (in_tready is an output)
//   in_tretx            : beat belongs to a retransmitted frame
//   m_axis_t*           : registered stream towards the MAC
//   m_axis_tretx        : registered retx marker, aligned with the beat
// ---------------------------------------------------------------------------
module reli_tx_out_reg
  import reli_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = DEF_USER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  input  logic [KEEP_WIDTH-1:0] in_tkeep,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic                  in_tlast,
  input  logic [USER_WIDTH-1:0] in_tuser,
  input  logic                  in_tretx,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tretx
);

  // Low while reset is asserted so that no upstream beat is accepted
  // (tready must read 0 during reset even if upstream still drives tvalid).
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  assign in_tready = run && (!m_axis_tvalid || m_axis_tready);

  // The payload only moves when the slot is free, so a stalled beat keeps
  // its data stable until the MAC takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tretx  <= 1'b0;
    end else if (in_tready) begin
      m_axis_tvalid <= in_tvalid;
      if (in_tvalid) begin
        m_axis_tdata <= in_tdata;
        m_axis_tkeep <= in_tkeep;
        m_axis_tlast <= in_tlast;
        m_axis_tuser <= in_tuser;
        m_axis_tretx <= in_tretx;
      end
    end
  end

endmodule

// File: rtl/reli_tx_mac_arb.sv
// ---------------------------------------------------------------------------
// reli_tx_mac_arb
// Frame-level arbiter between fresh traffic and retransmitted frames, driving
// one AXI-Stream master into the MAC. Retransmissions win, but after
// RETX_BURST_MAX consecutive retx grants with a fresh frame waiting, the
// fresh frame goes next. Frames are never interleaved, split or dropped.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axis_new_*        : fresh frames from the TX pipeline
//   s_axis_retx_*       : replayed frames from the retransmit buffer
//   m_axis_*            : merged stream into the MAC
//   m_axis_tretx        : high on every beat of a retx-sourced frame
//   reliable_enable     : 0 blocks new retx grants (current frame completes)
//   stat_new_frames     : fresh frames accepted (wrapping)
//   stat_retx_frames    : retx frames accepted (wrapping)
//   busy                : a frame is in progress or the output holds a beat
// ---------------------------------------------------------------------------
module reli_tx_mac_arb
  import reli_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int USER_WIDTH     = DEF_USER_WIDTH,
  parameter int RETX_BURST_MAX = 4,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_new_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_new_tkeep,
  input  logic                  s_axis_new_tvalid,
  output logic                  s_axis_new_tready,
  input  logic                  s_axis_new_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_new_tuser,
  input  logic [DATA_WIDTH-1:0] s_axis_retx_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_retx_tkeep,
  input  logic                  s_axis_retx_tvalid,
  output logic                  s_axis_retx_tready,
  input  logic                  s_axis_retx_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_retx_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tretx,
  input  logic                  reliable_enable,
  output logic [CNT_WIDTH-1:0]  stat_new_frames,
  output logic [CNT_WIDTH-1:0]  stat_retx_frames,
  output logic                  busy
);

  localparam int BW = $clog2(RETX_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(RETX_BURST_MAX);

  grant_t          state;
  grant_t          state_nxt;
  grant_t          src;
  logic [BW-1:0]   burst_cnt;

  logic [DATA_WIDTH-1:0] mux_tdata;
  logic [KEEP_WIDTH-1:0] mux_tkeep;
  logic                  mux_tvalid;
  logic                  mux_tlast;
  logic [USER_WIDTH-1:0] mux_tuser;
  logic                  out_free;
  logic                  accept;
  logic                  grant_evt;

  // Source selection. While a frame is in flight the owner is the state
  // itself; only in NONE is a fresh choice made, combinationally, so the
  // first beat of the chosen frame moves in the same cycle.
  always_comb begin
    src = state;
    if (state == GNT_NONE) begin
      if (s_axis_retx_tvalid && reliable_enable &&
          !(s_axis_new_tvalid && (burst_cnt == BURST_MAX))) begin
        src = GNT_RETX;
      end else if (s_axis_new_tvalid) begin
        src = GNT_NEW;
      end else begin
        src = GNT_NONE;
      end
    end
  end

  always_comb begin
    mux_tdata  = s_axis_new_tdata;
    mux_tkeep  = s_axis_new_tkeep;
    mux_tlast  = s_axis_new_tlast;
    mux_tuser  = s_axis_new_tuser;
    mux_tvalid = 1'b0;
    case (src)
      GNT_NEW: begin
        mux_tvalid = s_axis_new_tvalid;
      end
      GNT_RETX: begin
        mux_tdata  = s_axis_retx_tdata;
        mux_tkeep  = s_axis_retx_tkeep;
        mux_tlast  = s_axis_retx_tlast;
        mux_tuser  = s_axis_retx_tuser;
        mux_tvalid = s_axis_retx_tvalid;
      end
      default: begin
        mux_tvalid = 1'b0;
      end
    endcase
  end

  assign s_axis_new_tready  = (src == GNT_NEW)  && out_free;
  assign s_axis_retx_tready = (src == GNT_RETX) && out_free;
  assign accept             = mux_tvalid && out_free;
  assign grant_evt          = (state == GNT_NONE) && accept;

  // A single-beat frame never leaves NONE, which keeps back-to-back
  // single-beat frames from either source at one beat per cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      GNT_NONE: begin
        if (accept && !mux_tlast) begin
          state_nxt = src;
        end
      end
      GNT_NEW, GNT_RETX: begin
        if (accept && mux_tlast) begin
          state_nxt = GNT_NONE;
        end
      end
      default: begin
        state_nxt = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= GNT_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  // Burst counter only advances while fresh traffic is actually waiting,
  // so an idle fresh source never costs retx bandwidth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt <= '0;
    end else if (grant_evt) begin
      if (src == GNT_NEW) begin
        burst_cnt <= '0;
      end else if ((src == GNT_RETX) && s_axis_new_tvalid &&
                   (burst_cnt != BURST_MAX)) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_new_frames  <= '0;
      stat_retx_frames <= '0;
    end else if (accept && mux_tlast) begin
      if (src == GNT_NEW) begin
        stat_new_frames <= stat_new_frames + 1'b1;
      end else if (src == GNT_RETX) begin
        stat_retx_frames <= stat_retx_frames + 1'b1;
      end
    end
  end

  assign busy = (state != GNT_NONE) || m_axis_tvalid;

  reli_tx_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_tdata      (mux_tdata),
    .in_tkeep      (mux_tkeep),
    .in_tvalid     (mux_tvalid),
    .in_tready     (out_free),
    .in_tlast      (mux_tlast),
    .in_tuser      (mux_tuser),
    .in_tretx      (src == GNT_RETX),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tretx  (m_axis_tretx)
  );

endmodule

// File: tb/tb_reli_tx_mac_arb.sv
// ---------------------------------------------------------------------------
// tb_reli_tx_mac_arb
// Scoreboard bench for reli_tx_mac_arb: stimulus pushes expected beats into
// a queue, a monitor on the falling edge pops and compares every beat the
// DUT hands to the MAC.
// ---------------------------------------------------------------------------
module tb_reli_tx_mac_arb;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 71;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_new_tdata = '0;
  logic [KW-1:0] s_axis_new_tkeep = '0;
  logic          s_axis_new_tvalid = 1'b0;
  logic          s_axis_new_tready;
  logic          s_axis_new_tlast = 1'b0;
  logic [UW-1:0] s_axis_new_tuser = '0;
  logic [DW-1:0] s_axis_retx_tdata = '0;
  logic [KW-1:0] s_axis_retx_tkeep = '0;
  logic          s_axis_retx_tvalid = 1'b0;
  logic          s_axis_retx_tready;
  logic          s_axis_retx_tlast = 1'b0;
  logic [UW-1:0] s_axis_retx_tuser = '0;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tretx;
  logic          reliable_enable = 1'b1;
  logic [CW-1:0] stat_new_frames;
  logic [CW-1:0] stat_retx_frames;
  logic          busy;

  reli_tx_mac_arb #(
    .DATA_WIDTH     (DW),
    .KEEP_WIDTH     (KW),
    .USER_WIDTH     (UW),
    .RETX_BURST_MAX (4),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_axis_new_tdata   (s_axis_new_tdata),
    .s_axis_new_tkeep   (s_axis_new_tkeep),
    .s_axis_new_tvalid  (s_axis_new_tvalid),
    .s_axis_new_tready  (s_axis_new_tready),
    .s_axis_new_tlast   (s_axis_new_tlast),
    .s_axis_new_tuser   (s_axis_new_tuser),
    .s_axis_retx_tdata  (s_axis_retx_tdata),
    .s_axis_retx_tkeep  (s_axis_retx_tkeep),
    .s_axis_retx_tvalid (s_axis_retx_tvalid),
    .s_axis_retx_tready (s_axis_retx_tready),
    .s_axis_retx_tlast  (s_axis_retx_tlast),
    .s_axis_retx_tuser  (s_axis_retx_tuser),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tretx       (m_axis_tretx),
    .reliable_enable    (reliable_enable),
    .stat_new_frames    (stat_new_frames),
    .stat_retx_frames   (stat_retx_frames),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
    logic          retx;
    int            burst;
  } exp_t;

  exp_t expQ[$];
  int   popCyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [DW-1:0] mkData(input bit isRetx, input int frame, input int beat);
    logic [7:0] tag;
    logic [7:0] f;
    logic [7:0] b;
    tag = isRetx ? 8'hBB : 8'h11;
    f = frame[7:0];
    b = beat[7:0];
    return {8'hA5, 88'h0, tag, f, b, 8'h5A};
  endfunction

  function automatic logic [UW-1:0] mkUser(input bit isRetx, input int frame, input int beat);
    logic [7:0] tag;
    logic [7:0] f;
    logic [7:0] b;
    tag = isRetx ? 8'hCC : 8'h22;
    f = frame[7:0];
    b = beat[7:0];
    return {39'h0, tag, f, b, 8'hC3};
  endfunction

  function automatic logic [KW-1:0] mkKeep(input bit last);
    return last ? 16'h0FFF : 16'hFFFF;
  endfunction

  function automatic void pushExp(input bit isRetx, input int frame, input int beat,
                                  input bit last, input int burst);
    exp_t e;
    e.data  = mkData(isRetx, frame, beat);
    e.keep  = mkKeep(last);
    e.last  = last;
    e.user  = mkUser(isRetx, frame, beat);
    e.retx  = isRetx;
    e.burst = burst;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Present one beat on a source and block until it is accepted. Called
  // just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input bit isRetx, input int frame, input int beat,
                               input bit last, output int accCyc);
    bit hs;
    int guard;
    hs = 1'b0;
    guard = 0;
    accCyc = -1;
    if (isRetx) begin
      s_axis_retx_tdata  = mkData(1'b1, frame, beat);
      s_axis_retx_tkeep  = mkKeep(last);
      s_axis_retx_tlast  = last;
      s_axis_retx_tuser  = mkUser(1'b1, frame, beat);
      s_axis_retx_tvalid = 1'b1;
    end else begin
      s_axis_new_tdata  = mkData(1'b0, frame, beat);
      s_axis_new_tkeep  = mkKeep(last);
      s_axis_new_tlast  = last;
      s_axis_new_tuser  = mkUser(1'b0, frame, beat);
      s_axis_new_tvalid = 1'b1;
    end
    while (!hs && guard < 200) begin
      @(negedge clk);
      hs = isRetx ? (s_axis_retx_tvalid && s_axis_retx_tready)
                  : (s_axis_new_tvalid && s_axis_new_tready);
      if (hs) accCyc = cyc;
      guard++;
      @(posedge clk);
      #1;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=not_accepted required=accepted src=%0d frame=%0d beat=%0d",
               isRetx, frame, beat);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_m_tvalid"}, DW'(m_axis_tvalid), '0);
    checkOutput({tag, "_m_tdata"}, m_axis_tdata, '0);
    checkOutput({tag, "_m_tkeep"}, DW'(m_axis_tkeep), '0);
    checkOutput({tag, "_m_tuser"}, DW'(m_axis_tuser), '0);
    checkOutput({tag, "_m_tlast"}, DW'(m_axis_tlast), '0);
    checkOutput({tag, "_m_tretx"}, DW'(m_axis_tretx), '0);
    checkOutput({tag, "_new_tready"}, DW'(s_axis_new_tready), '0);
    checkOutput({tag, "_retx_tready"}, DW'(s_axis_retx_tready), '0);
    checkOutput({tag, "_busy"}, DW'(busy), '0);
    checkOutput({tag, "_stat_new"}, DW'(stat_new_frames), '0);
    checkOutput({tag, "_stat_retx"}, DW'(stat_retx_frames), '0);
    checkOutput({tag, "_burst_cnt"}, DW'(dut.burst_cnt), '0);
  endtask

  // Monitor: compare every beat the MAC accepts against the scoreboard, and
  // check that a stalled beat stays put until taken.
  initial begin
    exp_t          e;
    bit            prevStalled;
    logic [DW-1:0] prevData;
    prevStalled = 1'b0;
    prevData = '0;
    forever begin
      @(negedge clk);
      if (rst_n && prevStalled) begin
        checkOutput("stall_tvalid_hold", DW'(m_axis_tvalid), DW'(1'b1));
        checkOutput("stall_tdata_hold", m_axis_tdata, prevData);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%0h required=no_beat", m_axis_tdata);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_tdata", m_axis_tdata, e.data);
          checkOutput("beat_tkeep", DW'(m_axis_tkeep), DW'(e.keep));
          checkOutput("beat_tlast", DW'(m_axis_tlast), DW'(e.last));
          checkOutput("beat_tuser", DW'(m_axis_tuser), DW'(e.user));
          checkOutput("beat_tretx", DW'(m_axis_tretx), DW'(e.retx));
          if (e.burst >= 0) begin
            checkOutput("burst_cnt", DW'(dut.burst_cnt), DW'(e.burst));
          end
        end
        popCyc.push_back(cyc);
      end
      prevStalled = rst_n && m_axis_tvalid && !m_axis_tready;
      prevData = m_axis_tdata;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  acc;
    int  acc3[3];
    int  base;
    bit  done;

    // Reset state
    #3;
    checkResetState("rst0");
    #19;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: fresh 3-beat frame only
    $display("[TB] test1 fresh-only 3-beat frame");
    base = popCyc.size();
    for (int b = 0; b < 3; b++) begin
      pushExp(1'b0, 1, b, b == 2, -1);
    end
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, 1, b, b == 2, acc);
      acc3[b] = acc;
      checkOutput("t1_retx_tready_idle", DW'(s_axis_retx_tready), '0);
      checkOutput("t1_busy", DW'(busy), DW'(1'b1));
    end
    s_axis_new_tvalid = 1'b0;
    waitCycles(3);
    for (int b = 0; b < 3; b++) begin
      checkOutput("t1_latency", DW'(popCyc[base + b]), DW'(acc3[b] + 1));
    end
    checkOutput("t1_stat_new", DW'(stat_new_frames), DW'(1));
    checkOutput("t1_stat_retx", DW'(stat_retx_frames), '0);
    checkOutput("t1_busy_idle", DW'(busy), '0);

    // Test 2: both sources busy, 2-beat frames, burst bound of 4
    $display("[TB] test2 retx burst bound");
    base = popCyc.size();
    for (int g = 0; g < 2; g++) begin
      for (int r = 0; r < 4; r++) begin
        pushExp(1'b1, g * 4 + r, 0, 1'b0, r + 1);
        pushExp(1'b1, g * 4 + r, 1, 1'b1, -1);
      end
      pushExp(1'b0, 10 + g, 0, 1'b0, 0);
      pushExp(1'b0, 10 + g, 1, 1'b1, -1);
    end
    fork
      begin
        int a;
        for (int f = 0; f < 8; f++) begin
          for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b1, f, b, b == 1, a);
          end
        end
        s_axis_retx_tvalid = 1'b0;
      end
      begin
        int a;
        for (int f = 0; f < 2; f++) begin
          for (int b = 0; b < 2; b++) begin
            applyStimulus(1'b0, 10 + f, b, b == 1, a);
          end
        end
        s_axis_new_tvalid = 1'b0;
      end
    join
    waitCycles(3);
    checkOutput("t2_beat_count", DW'(popCyc.size() - base), DW'(20));
    if (popCyc.size() - base == 20) begin
      checkOutput("t2_no_bubble", DW'(popCyc[base + 19] - popCyc[base]), DW'(19));
    end
    checkOutput("t2_stat_new", DW'(stat_new_frames), DW'(3));
    checkOutput("t2_stat_retx", DW'(stat_retx_frames), DW'(8));

    // Test 3: reliable_enable dropped in the middle of a retx frame
    $display("[TB] test3 enable drop mid-retx");
    for (int b = 0; b < 4; b++) begin
      pushExp(1'b1, 20, b, b == 3, (b == 0) ? 1 : -1);
    end
    pushExp(1'b0, 21, 0, 1'b0, 0);
    pushExp(1'b0, 21, 1, 1'b1, -1);
    pushExp(1'b1, 22, 0, 1'b1, 0);
    fork
      begin
        int a;
        applyStimulus(1'b1, 20, 0, 1'b0, a);
        applyStimulus(1'b1, 20, 1, 1'b0, a);
        reliable_enable = 1'b0;
        applyStimulus(1'b1, 20, 2, 1'b0, a);
        applyStimulus(1'b1, 20, 3, 1'b1, a);
        applyStimulus(1'b1, 22, 0, 1'b1, a);
        s_axis_retx_tvalid = 1'b0;
      end
      begin
        int a;
        applyStimulus(1'b0, 21, 0, 1'b0, a);
        applyStimulus(1'b0, 21, 1, 1'b1, a);
        s_axis_new_tvalid = 1'b0;
        reliable_enable = 1'b1;
      end
    join
    waitCycles(3);
    checkOutput("t3_stat_new", DW'(stat_new_frames), DW'(4));
    checkOutput("t3_stat_retx", DW'(stat_retx_frames), DW'(10));

    // Test 4: MAC tready toggling every cycle, 5-beat fresh frame
    $display("[TB] test4 output backpressure");
    for (int b = 0; b < 5; b++) begin
      pushExp(1'b0, 30, b, b == 4, -1);
    end
    done = 1'b0;
    fork
      begin
        int a;
        for (int b = 0; b < 5; b++) begin
          applyStimulus(1'b0, 30, b, b == 4, a);
        end
        s_axis_new_tvalid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_axis_tready = !m_axis_tready;
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (s_axis_new_tvalid) begin
            checkOutput("t4_tready_mirror", DW'(s_axis_new_tready),
                        DW'(!m_axis_tvalid || m_axis_tready));
          end
        end
      end
    join
    m_axis_tready = 1'b1;
    waitCycles(4);
    checkOutput("t4_drained", DW'(expQ.size()), '0);
    checkOutput("t4_stat_new", DW'(stat_new_frames), DW'(5));

    // Test 5: single-beat frames alternating sources after a fresh reset
    $display("[TB] test5 single-beat alternating");
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = popCyc.size();
    for (int i = 0; i < 16; i++) begin
      pushExp(i % 2 == 1, 40 + i, 0, 1'b1, -1);
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 1) begin
        s_axis_new_tvalid = 1'b0;
        applyStimulus(1'b1, 40 + i, 0, 1'b1, acc);
      end else begin
        s_axis_retx_tvalid = 1'b0;
        applyStimulus(1'b0, 40 + i, 0, 1'b1, acc);
      end
      checkOutput("t5_fsm_none", DW'(dut.state), '0);
    end
    s_axis_new_tvalid = 1'b0;
    s_axis_retx_tvalid = 1'b0;
    waitCycles(3);
    checkOutput("t5_beat_count", DW'(popCyc.size() - base), DW'(16));
    if (popCyc.size() - base == 16) begin
      checkOutput("t5_one_per_cycle", DW'(popCyc[base + 15] - popCyc[base]), DW'(15));
    end
    checkOutput("t5_stat_new", DW'(stat_new_frames), DW'(8));
    checkOutput("t5_stat_retx", DW'(stat_retx_frames), DW'(8));

    // Test 6: reset asserted on beat 2 of a 4-beat frame
    $display("[TB] test6 reset mid-frame");
    pushExp(1'b0, 50, 0, 1'b0, -1);
    applyStimulus(1'b0, 50, 0, 1'b0, acc);
    applyStimulus(1'b0, 50, 1, 1'b0, acc);
    s_axis_new_tdata = mkData(1'b0, 50, 2);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("rst_mid");
    s_axis_new_tvalid = 1'b0;
    s_axis_new_tlast = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pushExp(1'b0, 51, 0, 1'b1, -1);
    applyStimulus(1'b0, 51, 0, 1'b1, acc);
    s_axis_new_tvalid = 1'b0;
    waitCycles(3);
    checkOutput("t6_stat_new", DW'(stat_new_frames), DW'(1));
    checkOutput("t6_stat_retx", DW'(stat_retx_frames), '0);
    checkOutput("final_queue_empty", DW'(expQ.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
